decode_stage: RTL and testbench

- Registered RISC-V instruction decode stage, parametrised in XLEN (32/64), with valid/ready handshakes on both sides.
- A two-entry skid buffer gives full throughput under backpressure.
- Adds illegal-instruction detection, unified format-selected immediate, memory access size/sign and CSR op classification.
- Sits between the fetch unit and the register-read/execute stage.

---
 rtl/decode_pkg.sv | 68 ++++++
 rtl/decode_logic.sv | 92 +++++++++
 rtl/decode_stage.sv | 163 ++++++++++++++++
 tb/tb_decode_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types for the RISC-V decode stage: opcode constants, field encodings,
// the decoded-entry record and the skid-buffer state.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RC   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RW   = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    MEM_BYTE   = 2'd0,
    MEM_HALF   = 2'd1,
    MEM_WORD   = 2'd2,
    MEM_DOUBLE = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // XLEN-wide fields (imm, pc) are carried beside this record by the stage.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    mem_size_e  mem_size;
    logic       mem_unsigned;
    csr_op_e    csr_op;
    logic       csr_imm;
    logic       illegal;
  } dec_entry_t;

  // CSRRW/CSRRS/CSRRC (and immediate forms) differ only in func3[1:0].
  function automatic csr_op_e csr_op_from_func3(input logic [1:0] f3_lo);
    csr_op_e op;
    case (f3_lo)
      2'b01:   op = CSR_RW;
      2'b10:   op = CSR_RS;
      2'b11:   op = CSR_RC;
      default: op = CSR_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Purely combinational RV32/RV64 instruction decoder: field extraction,
// format-selected immediate, control classification and illegal detection.
module decode_logic
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit CSR_EN = 1'b1
) (
  input  logic [31:0]     i_instr,
  output dec_entry_t      o_entry,
  output logic [XLEN-1:0] o_imm
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd;
  logic [31:0] w_imm32;
  logic        w_illegal;
  logic        w_wr_class;
  logic        w_csr_form;
  csr_op_e     w_csr_op;
  logic        w_is_load;
  logic        w_is_store;

  assign w_opcode   = i_instr[6:0];
  assign w_f3       = i_instr[14:12];
  assign w_rd       = i_instr[11:7];
  assign w_is_load  = (w_opcode == OP_LOAD);
  assign w_is_store = (w_opcode == OP_STORE);

  always_comb begin
    w_imm32 = 32'd0;
    case (w_opcode)
      OP_LOAD, OP_JALR, OP_IMM: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      OP_STORE:  w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OP_BRANCH: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: w_imm32 = {i_instr[31:12], 12'h000};
      OP_JAL:    w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
      default:   w_imm32 = 32'd0;
    endcase
  end

  always_comb begin
    w_illegal  = 1'b0;
    w_wr_class = 1'b0;
    w_csr_form = 1'b0;
    case (w_opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP: w_wr_class = 1'b1;
      OP_LOAD: begin
        w_wr_class = 1'b1;
        w_illegal  = (w_f3 == 3'b111) ||
                     ((XLEN == 32) && ((w_f3 == 3'b011) || (w_f3 == 3'b110)));
      end
      OP_STORE:  w_illegal = w_f3[2] || ((XLEN == 32) && (w_f3 == 3'b011));
      OP_BRANCH: w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      OP_SYSTEM: begin
        // func3 == 000 is ECALL/EBREAK, which stays legal without CSRs
        w_csr_form = (w_f3 != 3'b000);
        w_illegal  = w_csr_form && !CSR_EN;
      end
      default:   w_illegal = 1'b1;
    endcase
    w_illegal = w_illegal || (i_instr[1:0] != 2'b11);
    w_csr_op  = w_csr_form ? csr_op_from_func3(w_f3[1:0]) : CSR_NONE;
  end

  always_comb begin
    o_entry              = '0;
    o_entry.rs1          = i_instr[19:15];
    o_entry.rs2          = i_instr[24:20];
    o_entry.rd           = w_rd;
    o_entry.opcode       = w_opcode;
    o_entry.func3        = w_f3;
    o_entry.func7        = i_instr[31:25];
    o_entry.reg_write    = !w_illegal && (w_rd != 5'd0) &&
                           (w_wr_class || (w_csr_op != CSR_NONE));
    o_entry.branch       = !w_illegal && (w_opcode == OP_BRANCH);
    o_entry.jump         = !w_illegal && ((w_opcode == OP_JAL) || (w_opcode == OP_JALR));
    o_entry.mem_read     = !w_illegal && w_is_load;
    o_entry.mem_write    = !w_illegal && w_is_store;
    o_entry.mem_size     = (w_is_load || w_is_store) ? mem_size_e'(w_f3[1:0]) : MEM_BYTE;
    o_entry.mem_unsigned = w_is_load && w_f3[2];
    o_entry.csr_op       = w_illegal ? CSR_NONE : w_csr_op;
    o_entry.csr_imm      = w_csr_form && w_f3[2];
    o_entry.illegal      = w_illegal;
  end

  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a two-entry skid buffer; in_ready depends only
// on the registered buffer state, never combinationally on out_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit CSR_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_instr,
  input  logic [XLEN-1:0] i_in_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_func3,
  output logic [6:0]      o_func7,
  output logic [XLEN-1:0] o_imm,
  output logic            o_reg_write,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic [1:0]      o_mem_size,
  output logic            o_mem_unsigned,
  output logic [1:0]      o_csr_op,
  output logic            o_csr_imm,
  output logic            o_illegal
);

  dec_entry_t      w_dec;
  logic [XLEN-1:0] w_dec_imm;
  skid_state_e     r_state;
  skid_state_e     w_next_state;
  logic            r_out_valid;
  logic            r_in_ready;
  dec_entry_t      r_head;
  dec_entry_t      r_skid;
  logic [XLEN-1:0] r_head_imm;
  logic [XLEN-1:0] r_skid_imm;
  logic [XLEN-1:0] r_head_pc;
  logic [XLEN-1:0] r_skid_pc;
  logic            w_accept;
  logic            w_drain;
  logic            w_load_head;
  logic            w_head_from_skid;
  logic            w_load_skid;

  decode_logic #(
    .XLEN   (XLEN),
    .CSR_EN (CSR_EN)
  ) u_decode (
    .i_instr (i_in_instr),
    .o_entry (w_dec),
    .o_imm   (w_dec_imm)
  );

  assign w_accept = i_in_valid && r_in_ready;
  assign w_drain  = r_out_valid && i_out_ready;

  always_comb begin
    w_next_state     = r_state;
    w_load_head      = 1'b0;
    w_head_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next_state = ST_ONE;
          w_load_head  = 1'b1;
        end else begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_ONE: begin
        case ({w_accept, w_drain})
          2'b10: begin
            w_next_state = ST_TWO;
            w_load_skid  = 1'b1;
          end
          2'b01:   w_next_state = ST_EMPTY;
          2'b11: begin
            w_next_state = ST_ONE;
            w_load_head  = 1'b1;
          end
          default: w_next_state = ST_ONE;
        endcase
      end
      ST_TWO: begin
        if (w_drain) begin
          w_next_state     = ST_ONE;
          w_load_head      = 1'b1;
          w_head_from_skid = 1'b1;
        end else begin
          w_next_state = ST_TWO;
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase
  end

  // Flush clears occupancy only; stale payload is hidden behind out_valid = 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_head      <= '0;
      r_skid      <= '0;
      r_head_imm  <= '0;
      r_skid_imm  <= '0;
      r_head_pc   <= '0;
      r_skid_pc   <= '0;
    end else if (i_flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_next_state;
      r_out_valid <= (w_next_state != ST_EMPTY);
      r_in_ready  <= (w_next_state != ST_TWO);
      if (w_load_head) begin
        r_head     <= w_head_from_skid ? r_skid     : w_dec;
        r_head_imm <= w_head_from_skid ? r_skid_imm : w_dec_imm;
        r_head_pc  <= w_head_from_skid ? r_skid_pc  : i_in_pc;
      end
      if (w_load_skid) begin
        r_skid     <= w_dec;
        r_skid_imm <= w_dec_imm;
        r_skid_pc  <= i_in_pc;
      end
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_out_valid    = r_out_valid;
  assign o_out_pc       = r_head_pc;
  assign o_imm          = r_head_imm;
  assign o_rs1          = r_head.rs1;
  assign o_rs2          = r_head.rs2;
  assign o_rd           = r_head.rd;
  assign o_opcode       = r_head.opcode;
  assign o_func3        = r_head.func3;
  assign o_func7        = r_head.func7;
  assign o_reg_write    = r_head.reg_write;
  assign o_branch       = r_head.branch;
  assign o_jump         = r_head.jump;
  assign o_mem_read     = r_head.mem_read;
  assign o_mem_write    = r_head.mem_write;
  assign o_mem_size     = r_head.mem_size;
  assign o_mem_unsigned = r_head.mem_unsigned;
  assign o_csr_op       = r_head.csr_op;
  assign o_csr_imm      = r_head.csr_imm;
  assign o_illegal      = r_head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: three instances (RV32, RV64, RV32 without
// CSRs) share one stimulus stream; expected values are hand-computed constants.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  logic        a_in_ready, a_out_valid, a_reg_write, a_branch, a_jump, a_mem_read, a_mem_write;
  logic        a_mem_unsigned, a_csr_imm, a_illegal;
  logic [31:0] a_out_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [6:0]  a_opcode, a_func7;
  logic [2:0]  a_func3;
  logic [1:0]  a_mem_size, a_csr_op;

  logic        b_in_ready, b_out_valid, b_reg_write, b_branch, b_jump, b_mem_read, b_mem_write;
  logic        b_mem_unsigned, b_csr_imm, b_illegal;
  logic [63:0] b_out_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [6:0]  b_opcode, b_func7;
  logic [2:0]  b_func3;
  logic [1:0]  b_mem_size, b_csr_op;

  logic        c_in_ready, c_out_valid, c_reg_write, c_branch, c_jump, c_mem_read, c_mem_write;
  logic        c_mem_unsigned, c_csr_imm, c_illegal;
  logic [31:0] c_out_pc, c_imm;
  logic [4:0]  c_rs1, c_rs2, c_rd;
  logic [6:0]  c_opcode, c_func7;
  logic [2:0]  c_func3;
  logic [1:0]  c_mem_size, c_csr_op;

  // control vector order: {reg_write, branch, jump, mem_read, mem_write, illegal}
  wire [5:0] a_ctl = {a_reg_write, a_branch, a_jump, a_mem_read, a_mem_write, a_illegal};
  wire [5:0] b_ctl = {b_reg_write, b_branch, b_jump, b_mem_read, b_mem_write, b_illegal};
  wire [5:0] c_ctl = {c_reg_write, c_branch, c_jump, c_mem_read, c_mem_write, c_illegal};

  decode_stage #(.XLEN(32), .CSR_EN(1'b1)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(a_in_ready),
    .i_in_instr(in_instr), .i_in_pc(in_pc), .o_out_valid(a_out_valid), .i_out_ready(out_ready),
    .o_out_pc(a_out_pc), .o_rs1(a_rs1), .o_rs2(a_rs2), .o_rd(a_rd), .o_opcode(a_opcode),
    .o_func3(a_func3), .o_func7(a_func7), .o_imm(a_imm), .o_reg_write(a_reg_write),
    .o_branch(a_branch), .o_jump(a_jump), .o_mem_read(a_mem_read), .o_mem_write(a_mem_write),
    .o_mem_size(a_mem_size), .o_mem_unsigned(a_mem_unsigned), .o_csr_op(a_csr_op),
    .o_csr_imm(a_csr_imm), .o_illegal(a_illegal));

  decode_stage #(.XLEN(64), .CSR_EN(1'b1)) u_dut64 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(b_in_ready),
    .i_in_instr(in_instr), .i_in_pc({32'd0, in_pc}), .o_out_valid(b_out_valid), .i_out_ready(out_ready),
    .o_out_pc(b_out_pc), .o_rs1(b_rs1), .o_rs2(b_rs2), .o_rd(b_rd), .o_opcode(b_opcode),
    .o_func3(b_func3), .o_func7(b_func7), .o_imm(b_imm), .o_reg_write(b_reg_write),
    .o_branch(b_branch), .o_jump(b_jump), .o_mem_read(b_mem_read), .o_mem_write(b_mem_write),
    .o_mem_size(b_mem_size), .o_mem_unsigned(b_mem_unsigned), .o_csr_op(b_csr_op),
    .o_csr_imm(b_csr_imm), .o_illegal(b_illegal));

  decode_stage #(.XLEN(32), .CSR_EN(1'b0)) u_dut_nocsr (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(c_in_ready),
    .i_in_instr(in_instr), .i_in_pc(in_pc), .o_out_valid(c_out_valid), .i_out_ready(out_ready),
    .o_out_pc(c_out_pc), .o_rs1(c_rs1), .o_rs2(c_rs2), .o_rd(c_rd), .o_opcode(c_opcode),
    .o_func3(c_func3), .o_func7(c_func7), .o_imm(c_imm), .o_reg_write(c_reg_write),
    .o_branch(c_branch), .o_jump(c_jump), .o_mem_read(c_mem_read), .o_mem_write(c_mem_write),
    .o_mem_size(c_mem_size), .o_mem_unsigned(c_mem_unsigned), .o_csr_op(c_csr_op),
    .o_csr_imm(c_csr_imm), .o_illegal(c_illegal));

  // Offer one instruction with out_ready high; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", a_in_ready); end
    checks++; if ({a_rd, a_imm, a_out_pc} !== 69'd0) begin errors++; $display("FAIL rst_payload got rd=%0d imm=%h pc=%h want 0", a_rd, a_imm, a_out_pc); end
    checks++; if (a_ctl !== 6'b000000) begin errors++; $display("FAIL rst_ctl got %b want 000000", a_ctl); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid got %b want 0", a_out_valid); end
  endtask

  task automatic test_alu_upper();
    send(32'hFFF08293, 32'h0000_0100);  // ADDI x5,x1,-1
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", a_out_valid); end
    checks++; if ({a_rd, a_rs1} !== {5'd5, 5'd1}) begin errors++; $display("FAIL addi_regs got rd=%0d rs1=%0d want 5 1", a_rd, a_rs1); end
    checks++; if (a_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", a_imm); end
    checks++; if (b_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL addi_imm64 got %h want all ones", b_imm); end
    checks++; if (a_ctl !== 6'b100000) begin errors++; $display("FAIL addi_ctl got %b want 100000", a_ctl); end
    checks++; if (a_out_pc !== 32'h0000_0100) begin errors++; $display("FAIL addi_pc got %h want 00000100", a_out_pc); end
    send(32'h800001B7, 32'h0000_0104);  // LUI x3,0x80000
    checks++; if (a_imm !== 32'h8000_0000) begin errors++; $display("FAIL lui_imm got %h want 80000000", a_imm); end
    checks++; if (b_imm !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL lui_imm64 got %h want ffffffff80000000", b_imm); end
    checks++; if (a_ctl !== 6'b100000) begin errors++; $display("FAIL lui_ctl got %b want 100000", a_ctl); end
  endtask

  task automatic test_memory();
    send(32'h0021A423, 32'h0000_0200);  // SW x2,8(x3)
    checks++; if (a_ctl !== 6'b000010) begin errors++; $display("FAIL sw_ctl got %b want 000010", a_ctl); end
    checks++; if ({a_mem_size, a_imm} !== {2'd2, 32'd8}) begin errors++; $display("FAIL sw_size_imm got %0d %h want 2 8", a_mem_size, a_imm); end
    send(32'h0021B423, 32'h0000_0204);  // SD x2,8(x3)
    checks++; if ({b_ctl, b_mem_size} !== {6'b000010, 2'd3}) begin errors++; $display("FAIL sd64 got ctl=%b size=%0d want 000010 3", b_ctl, b_mem_size); end
    checks++; if (a_ctl !== 6'b000001) begin errors++; $display("FAIL sd32_illegal got ctl=%b want 000001", a_ctl); end
    send(32'h0000C203, 32'h0000_0208);  // LBU x4,0(x1)
    checks++; if ({a_ctl, a_mem_size, a_mem_unsigned} !== {6'b100100, 2'd0, 1'b1}) begin errors++; $display("FAIL lbu got ctl=%b size=%0d uns=%b want 100100 0 1", a_ctl, a_mem_size, a_mem_unsigned); end
    send(32'h0000E203, 32'h0000_020C);  // LWU x4,0(x1)
    checks++; if ({b_ctl, b_mem_size, b_mem_unsigned} !== {6'b100100, 2'd2, 1'b1}) begin errors++; $display("FAIL lwu64 got ctl=%b size=%0d uns=%b want 100100 2 1", b_ctl, b_mem_size, b_mem_unsigned); end
    checks++; if (a_ctl !== 6'b000001) begin errors++; $display("FAIL lwu32_illegal got ctl=%b want 000001", a_ctl); end
  endtask

  task automatic test_control_flow();
    send(32'hFE000EE3, 32'h0000_0300);  // BEQ x0,x0,-4
    checks++; if (a_ctl !== 6'b010000) begin errors++; $display("FAIL beq_ctl got %b want 010000", a_ctl); end
    checks++; if (a_imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beq_imm got %h want fffffffc", a_imm); end
    checks++; if (b_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL beq_imm64 got %h want fffffffffffffffc", b_imm); end
    send(32'h0010006F, 32'h0000_0304);  // JAL x0,+2048
    checks++; if ({a_ctl, a_imm} !== {6'b001000, 32'h0000_0800}) begin errors++; $display("FAIL jal_x0 got ctl=%b imm=%h want 001000 800", a_ctl, a_imm); end
    send(32'h001000EF, 32'h0000_0308);  // JAL x1,+2048
    checks++; if (a_ctl !== 6'b101000) begin errors++; $display("FAIL jal_x1_ctl got %b want 101000", a_ctl); end
    send(32'h00002063, 32'h0000_030C);  // BRANCH func3=010
    checks++; if (a_ctl !== 6'b000001) begin errors++; $display("FAIL branch_f3_ctl got %b want 000001", a_ctl); end
  endtask

  task automatic test_csr_illegal();
    send(32'h300120F3, 32'h0000_0400);  // CSRRS x1,mstatus,x2
    checks++; if ({a_csr_op, a_csr_imm, a_ctl} !== {2'd2, 1'b0, 6'b100000}) begin errors++; $display("FAIL csrrs got op=%0d imm=%b ctl=%b want 2 0 100000", a_csr_op, a_csr_imm, a_ctl); end
    checks++; if (a_imm !== 32'd0) begin errors++; $display("FAIL csrrs_imm got %h want 0", a_imm); end
    checks++; if ({c_csr_op, c_ctl} !== {2'd0, 6'b000001}) begin errors++; $display("FAIL csrrs_nocsr got op=%0d ctl=%b want 0 000001", c_csr_op, c_ctl); end
    send(32'h3001F2F3, 32'h0000_0404);  // CSRRCI x5,mstatus,3
    checks++; if ({a_csr_op, a_csr_imm, a_ctl} !== {2'd1, 1'b1, 6'b100000}) begin errors++; $display("FAIL csrrci got op=%0d imm=%b ctl=%b want 1 1 100000", a_csr_op, a_csr_imm, a_ctl); end
    send(32'h00000073, 32'h0000_0408);  // ECALL
    checks++; if ({c_csr_op, c_ctl} !== {2'd0, 6'b000000}) begin errors++; $display("FAIL ecall_nocsr got op=%0d ctl=%b want 0 000000", c_csr_op, c_ctl); end
    send(32'h00000000, 32'h0000_040C);
    checks++; if ({a_out_valid, a_ctl, a_out_pc} !== {1'b1, 6'b000001, 32'h0000_040C}) begin errors++; $display("FAIL zero_word got v=%b ctl=%b pc=%h want 1 000001 40c", a_out_valid, a_ctl, a_out_pc); end
    send(32'h0000007F, 32'h0000_0410);  // unknown opcode
    checks++; if (a_ctl !== 6'b000001) begin errors++; $display("FAIL unknown_op got ctl=%b want 000001", a_ctl); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", a_out_valid); end
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h0000_0500;
    @(negedge clk);
    checks++; if ({a_in_ready, a_out_valid, a_rd} !== {1'b1, 1'b1, 5'd1}) begin errors++; $display("FAIL bp_one got rdy=%b v=%b rd=%0d want 1 1 1", a_in_ready, a_out_valid, a_rd); end
    in_instr = 32'h00200113; in_pc = 32'h0000_0504;
    @(negedge clk);
    checks++; if ({a_in_ready, a_rd} !== {1'b0, 5'd1}) begin errors++; $display("FAIL bp_two got rdy=%b rd=%0d want 0 1", a_in_ready, a_rd); end
    in_instr = 32'h00300193; in_pc = 32'h0000_0508;
    @(negedge clk);
    checks++; if ({a_in_ready, a_out_valid, a_rd, a_imm, a_out_pc} !== {1'b0, 1'b1, 5'd1, 32'd1, 32'h0000_0500}) begin errors++; $display("FAIL bp_stall got rdy=%b v=%b rd=%0d imm=%h pc=%h want 0 1 1 1 500", a_in_ready, a_out_valid, a_rd, a_imm, a_out_pc); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({a_in_ready, a_rd, a_out_pc} !== {1'b1, 5'd2, 32'h0000_0504}) begin errors++; $display("FAIL bp_second got rdy=%b rd=%0d pc=%h want 1 2 504", a_in_ready, a_rd, a_out_pc); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({a_out_valid, a_rd, a_out_pc} !== {1'b1, 5'd3, 32'h0000_0508}) begin errors++; $display("FAIL bp_third got v=%b rd=%0d pc=%h want 1 3 508", a_out_valid, a_rd, a_out_pc); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", a_out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h0000_0600;
    @(negedge clk);
    in_instr = 32'h00200113; in_pc = 32'h0000_0604;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_two got rdy=%b want 0", a_in_ready); end
    flush = 1'b1; in_instr = 32'h00400213; in_pc = 32'h0000_0608;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if ({a_out_valid, a_in_ready} !== 2'b01) begin errors++; $display("FAIL flush_state got v=%b rdy=%b want 0 1", a_out_valid, a_in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale cycle %0d got v=%b want 0", i, a_out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h0000_0700;
    @(negedge clk);
    in_instr = 32'h00200113;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({a_out_valid, a_in_ready} !== 2'b00) begin errors++; $display("FAIL rst_mid got v=%b rdy=%b want 0 0", a_out_valid, a_in_ready); end
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({a_out_valid, a_in_ready} !== 2'b01) begin errors++; $display("FAIL rst_mid_after got v=%b rdy=%b want 0 1", a_out_valid, a_in_ready); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale got v=%b want 0", a_out_valid); end
  endtask

  initial begin
    test_reset();
    test_alu_upper();
    test_memory();
    test_control_flow();
    test_csr_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
